// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes, status codes, operand-load keys
// and the controller state type.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_PLUS    = 4'b1110,
      OP_MINUS   = 4'b1101,
      OP_UMNOG   = 4'b1011,
      OP_DELEN   = 4'b0111,
      OP_DEFAULT = 4'b1111
   } op_e;

   typedef enum logic [2:0] {
      CODE_P  = 3'd0,
      CODE_M  = 3'd1,
      CODE_D0 = 3'd2,
      CODE_OV = 3'd3,
      CODE_D  = 3'd4
   } ctrl_e;

   typedef enum logic [1:0] {
      KEY_NONE = 2'b00,
      KEY_B    = 2'b01,
      KEY_A    = 2'b10,
      KEY_BOTH = 2'b11
   } key_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIN
   } state_e;

   // Only the four arithmetic codes launch an operation.
   function automatic logic op_valid(input logic [3:0] code);
      return code inside {OP_PLUS, OP_MINUS, OP_UMNOG, OP_DELEN};
   endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider: one quotient bit per clock, QW iterations after a start pulse.
// quotient holds its value until the next start; done pulses once when it is final.
module alu_div_iter
   import alu_pkg::*;
#(
   parameter int QW  = 18,
   parameter int REG = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [QW-1:0] dividend,
   input  logic [REG-1:0] divisor,
   output logic [QW-1:0] quotient,
   output logic          done
);

   localparam int CW = $clog2(QW + 1);

   logic [REG-1:0] rem_q, rem_d;
   logic [QW-1:0]  quo_q, quo_d;
   logic [REG-1:0] dvs_q, dvs_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           done_q, done_d;

   logic [REG:0]   shifted;
   logic [REG:0]   diff;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      shifted = {rem_q, quo_q[QW-1]};
      diff    = shifted - {1'b0, dvs_q};

      if (start) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
         cnt_d = CW'(QW);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
         // Remainder stays below the divisor, so the trial difference always fits REG bits.
         if (shifted >= {1'b0, dvs_q}) begin
            rem_d = diff[REG-1:0];
            quo_d = {quo_q[QW-2:0], 1'b1};
         end else begin
            rem_d = shifted[REG-1:0];
            quo_d = {quo_q[QW-2:0], 1'b0};
         end
         done_d = (cnt_q == CW'(1));
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign quotient = quo_q;
   assign done     = done_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: operand registers loaded by keys, multi-cycle add/sub/multiply/divide
// launched by start, with saturating registered result and status.
module alu_seq
   import alu_pkg::*;
#(
   parameter int REG   = 11,
   parameter int SCALE = 100
) (
   input  logic           clk_ALU,
   input  logic           rst_ALU,
   input  logic [3:0]     arif_from_top,
   input  logic [REG-1:0] in_numb_from_top,
   input  logic [1:0]     keys,
   input  logic           start,
   output logic [REG-1:0] ind_1,
   output logic [2:0]     control,
   output logic           busy,
   output logic           done
);

   localparam int SW = $clog2(SCALE);
   localparam int QW = REG + SW;
   localparam int CW = $clog2(REG + 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [REG-1:0]   a_q, a_d, b_q, b_d;
   logic [REG-1:0]   wa_q, wa_d, wb_q, wb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*REG-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [REG-1:0]   mplier_q, mplier_d;
   logic [REG-1:0]   ind_q, ind_d;
   ctrl_e            control_q, control_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic             div_start, div_done, calc_last;
   logic [QW-1:0]    div_dividend, div_quot;
   logic [REG:0]     sum;

   assign div_dividend = QW'(a_q) * QW'(SCALE);

   alu_div_iter #(.QW(QW), .REG(REG)) u_div (
      .clk      (clk_ALU),
      .rst      (rst_ALU),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (b_q),
      .quotient (div_quot),
      .done     (div_done)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      wa_d      = wa_q;
      wb_d      = wb_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      ind_d     = ind_q;
      control_d = control_q;
      busy_d    = (state_q != S_IDLE);
      done_d    = 1'b0;
      div_start = 1'b0;
      calc_last = 1'b0;
      sum       = {1'b0, wa_q} + {1'b0, wb_q};

      if (keys == KEY_A)      a_d = in_numb_from_top;
      else if (keys == KEY_B) b_d = in_numb_from_top;

      case (state_q)
         S_IDLE: begin
            if (start && op_valid(arif_from_top)) begin
               state_d   = S_CALC;
               op_d      = op_e'(arif_from_top);
               wa_d      = a_q;
               wb_d      = b_q;
               cnt_d     = (arif_from_top == OP_UMNOG) ? CW'(REG) : '0;
               acc_d     = '0;
               mcand_d   = {{REG{1'b0}}, a_q};
               mplier_d  = b_q;
               div_start = (arif_from_top == OP_DELEN) && (b_q != '0);
            end else if (arif_from_top == OP_DEFAULT) begin
               ind_d     = in_numb_from_top;
               control_d = CODE_P;
            end
         end
         S_CALC: begin
            if (op_q == OP_UMNOG && cnt_q != '0) begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q - CW'(1);
            end
            // A real division waits on the divider; everything else on the iteration count.
            calc_last = (op_q == OP_DELEN && wb_q != '0) ? div_done : (cnt_q == '0);
            if (calc_last) state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            case (op_q)
               OP_PLUS: begin
                  ind_d     = sum[REG] ? '1 : sum[REG-1:0];
                  control_d = sum[REG] ? CODE_OV : CODE_P;
               end
               OP_MINUS: begin
                  ind_d     = (wa_q < wb_q) ? (wb_q - wa_q) : (wa_q - wb_q);
                  control_d = (wa_q < wb_q) ? CODE_M : CODE_P;
               end
               OP_UMNOG: begin
                  ind_d     = (|acc_q[2*REG-1:REG]) ? '1 : acc_q[REG-1:0];
                  control_d = (|acc_q[2*REG-1:REG]) ? CODE_OV : CODE_P;
               end
               OP_DELEN: begin
                  if (wb_q == '0) begin
                     control_d = CODE_D0;
                  end else begin
                     ind_d     = (|div_quot[QW-1:REG]) ? '1 : div_quot[REG-1:0];
                     control_d = (|div_quot[QW-1:REG]) ? CODE_OV : CODE_D;
                  end
               end
               default: done_d = 1'b0;
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_ALU) begin
      if (rst_ALU) begin
         state_q   <= S_IDLE;
         op_q      <= OP_DEFAULT;
         a_q       <= '0;
         b_q       <= '0;
         wa_q      <= '0;
         wb_q      <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         ind_q     <= '0;
         control_q <= CODE_P;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         wa_q      <= wa_d;
         wb_q      <= wb_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         ind_q     <= ind_d;
         control_q <= control_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign ind_1   = ind_q;
   assign control = control_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes reference results, a monitor pops
// and compares them whenever done pulses.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int REG    = 11;
   localparam int MAXV   = (1 << REG) - 1;
   localparam int LAT_S  = 2;
   localparam int LAT_M  = REG + 2;
   localparam int LAT_D  = REG + 7 + 2;
   localparam logic [3:0] OP_IDLE = 4'b0000;

   typedef struct {
      int ind;
      int ctrl;
      int cyc;
   } exp_t;

   logic           clk_ALU = 1'b0;
   logic           rst_ALU;
   logic [3:0]     arif_from_top;
   logic [REG-1:0] in_numb_from_top;
   logic [1:0]     keys;
   logic           start;
   logic [REG-1:0] ind_1;
   logic [2:0]     control;
   logic           busy;
   logic           done;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   m_a = 0, m_b = 0, m_ind = 0;

   alu_seq dut (
      .clk_ALU          (clk_ALU),
      .rst_ALU          (rst_ALU),
      .arif_from_top    (arif_from_top),
      .in_numb_from_top (in_numb_from_top),
      .keys             (keys),
      .start            (start),
      .ind_1            (ind_1),
      .control          (control),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk_ALU = ~clk_ALU;
   always @(posedge clk_ALU) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour from the arithmetic rules; k is the edge that samples start.
   function automatic exp_t model(input logic [3:0] op, input int a, input int b,
                                  input int prev, input int k);
      exp_t e;
      int   r;
      case (op)
         OP_PLUS: begin
            r = a + b;
            e = '{(r > MAXV) ? MAXV : r, (r > MAXV) ? CODE_OV : CODE_P, k + LAT_S};
         end
         OP_MINUS:
            e = (a < b) ? '{b - a, CODE_M, k + LAT_S} : '{a - b, CODE_P, k + LAT_S};
         OP_UMNOG: begin
            r = a * b;
            e = '{(r > MAXV) ? MAXV : r, (r > MAXV) ? CODE_OV : CODE_P, k + LAT_M};
         end
         default: begin
            if (b == 0) begin
               e = '{prev, CODE_D0, k + LAT_S};
            end else begin
               r = (a * 100) / b;
               e = '{(r > MAXV) ? MAXV : r, (r > MAXV) ? CODE_OV : CODE_D, k + LAT_D};
            end
         end
      endcase
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk_ALU) begin
      if (!rst_ALU && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_ind_1", ind_1, e.ind);
            check("result_control", control, e.ctrl);
            check("result_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic load(input logic [1:0] k, input int v);
      keys = k;
      in_numb_from_top = REG'(v);
      @(negedge clk_ALU);
      keys = KEY_NONE;
      if (k == KEY_A) m_a = v;
      else if (k == KEY_B) m_b = v;
   endtask

   task automatic issue(input logic [3:0] op);
      exp_t e;
      e = model(op, m_a, m_b, m_ind, cyc + 1);
      sb.push_back(e);
      m_ind = e.ind;
      arif_from_top = op;
      start = 1'b1;
      @(negedge clk_ALU);
      start = 1'b0;
      arif_from_top = OP_IDLE;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk_ALU);
         t++;
      end
      check("drain_pending", sb.size(), 0);
      sb.delete();
   endtask

   task automatic op2(input int a, input int b, input logic [3:0] op);
      load(KEY_A, a);
      load(KEY_B, b);
      issue(op);
      drain();
   endtask

   initial begin
      exp_t e;
      rst_ALU = 1'b1;
      arif_from_top = OP_IDLE;
      in_numb_from_top = '0;
      keys = KEY_NONE;
      start = 1'b0;
      repeat (2) @(negedge clk_ALU);
      check("reset_ind_1", ind_1, 0);
      check("reset_control", control, CODE_P);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst_ALU = 1'b0;

      // PLUS with busy window
      load(KEY_A, 5);
      load(KEY_B, 3);
      issue(OP_PLUS);
      @(negedge clk_ALU); check("busy_k1", busy, 1);
      @(negedge clk_ALU); check("busy_k2", busy, 1);
      @(negedge clk_ALU); check("busy_k3", busy, 0);
      drain();

      op2(3, 10, OP_MINUS);
      op2(1500, 1000, OP_PLUS);
      op2(40, 60, OP_UMNOG);
      op2(40, 50, OP_UMNOG);
      op2(7, 2, OP_DELEN);
      op2(7, 0, OP_DELEN);
      op2(0, 0, OP_PLUS);
      op2(2047, 2047, OP_MINUS);

      // start held high: FIN-cycle start dropped, following one accepted
      load(KEY_A, 20);
      load(KEY_B, 22);
      sb.push_back(model(OP_PLUS, 20, 22, m_ind, cyc + 1));
      e = model(OP_PLUS, 20, 22, m_ind, cyc + 4);
      sb.push_back(e);
      m_ind = e.ind;
      arif_from_top = OP_PLUS;
      start = 1'b1;
      repeat (4) @(negedge clk_ALU);
      start = 1'b0;
      arif_from_top = OP_IDLE;
      drain();

      // Unlisted code with start: no launch, result held
      arif_from_top = 4'b0011;
      start = 1'b1;
      repeat (3) @(negedge clk_ALU);
      start = 1'b0;
      arif_from_top = OP_IDLE;
      check("bad_op_busy", busy, 0);
      check("bad_op_hold", ind_1, m_ind);

      // Division ignores a restart and a B rewrite while busy
      load(KEY_A, 7);
      load(KEY_B, 2);
      issue(OP_DELEN);
      repeat (4) @(negedge clk_ALU);
      arif_from_top = OP_PLUS;
      start = 1'b1;
      load(KEY_B, 9);
      start = 1'b0;
      arif_from_top = OP_IDLE;
      drain();

      // Reset mid-division aborts without done
      arif_from_top = OP_DELEN;
      start = 1'b1;
      @(negedge clk_ALU);
      start = 1'b0;
      arif_from_top = OP_IDLE;
      repeat (7) @(negedge clk_ALU);
      check("mid_op_busy", busy, 1);
      rst_ALU = 1'b1;
      start = 1'b1;
      keys = KEY_A;
      @(negedge clk_ALU);
      rst_ALU = 1'b0;
      start = 1'b0;
      keys = KEY_NONE;
      check("abort_ind_1", ind_1, 0);
      check("abort_control", control, CODE_P);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      m_a = 0; m_b = 0; m_ind = 0;
      repeat (25) @(negedge clk_ALU);
      check("abort_busy_later", busy, 0);
      op2(0, 0, OP_DELEN);

      // DEFAULT pass-through, with start toggling (must not launch)
      arif_from_top = OP_DEFAULT;
      for (int v = 0; v <= MAXV; v++) begin
         in_numb_from_top = REG'(v);
         start = v[0];
         @(negedge clk_ALU);
         check("pass_ind_1", ind_1, v);
         check("pass_control", control, CODE_P);
      end
      start = 1'b0;
      arif_from_top = OP_IDLE;
      m_ind = MAXV;

      // Randomised operations
      for (int i = 0; i < 150; i++) begin
         logic [3:0] op;
         int         sel;
         sel = $urandom_range(0, 3);
         op  = (sel == 0) ? OP_PLUS : (sel == 1) ? OP_MINUS : (sel == 2) ? OP_UMNOG : OP_DELEN;
         if ($urandom_range(0, 3) == 0) load(KEY_BOTH, $urandom_range(0, MAXV));
         load(KEY_A, ($urandom_range(0, 1) == 1) ? $urandom_range(0, MAXV) : $urandom_range(0, 63));
         if (op == OP_DELEN && $urandom_range(0, 4) == 0) load(KEY_B, 0);
         else load(KEY_B, ($urandom_range(0, 1) == 1) ? $urandom_range(0, MAXV) : $urandom_range(1, 63));
         issue(op);
         drain();
      end

      repeat (5) @(negedge clk_ALU);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
